// File: rtl/uart_rx_fifo_param.sv
// UART receiver: 2-flop synchronizer, baud divider, oversampling FSM and FWFT RX FIFO.
// Define UART_RX_TIMEOUT_EN to build the character-timeout counter (otherwise timeout_o is tied 0).
module uart_rx_fifo_param #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIV_WIDTH-1:0]          baud_div_i,
    input  logic [1:0]                    cfg_data_bits_i,
    input  logic                          cfg_parity_en_i,
    input  logic                          cfg_parity_odd_i,
    input  logic [$clog2(FIFO_DEPTH):0]   cfg_trig_lvl_i,
    input  logic                          rxd_i,
    input  logic                          rd_en_i,
    output logic [7:0]                    rd_data_o,
    output logic [2:0]                    rd_err_o,
    output logic                          rx_empty_o,
    output logic                          rx_full_o,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count_o,
    output logic                          overrun_o,
    output logic                          rx_trig_o,
    output logic                          rts_o,
    output logic                          timeout_o
);

    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned OSW = $clog2(OVERSAMPLE);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic rxd_meta, rxd_s, rxd_prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd_i;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
        end
    end

    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 tick, div_clr;
    assign tick = (div_cnt >= baud_div_i);

    // Divider restarts on start detection so bit sampling phase is frame-relative.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                div_cnt <= '0;
        else if (div_clr || tick)  div_cnt <= '0;
        else                       div_cnt <= div_cnt + 1'b1;
    end

    state_t         state_q, state_d;
    logic [OSW-1:0] os_q, os_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [1:0]     nb_q, nb_d;
    logic           pen_q, pen_d, podd_q, podd_d, pbit_q, pbit_d;
    logic           wait_q, wait_d, push_q, push_d;
    logic [10:0]    word_q, word_d;
    logic           last_bit, par_err, frm_err, brk;

    assign last_bit = (bit_q == (3'd4 + {1'b0, nb_q}));
    assign frm_err  = !rxd_s;
    assign par_err  = pen_q && (pbit_q != (^shreg_q ^ podd_q));
    assign brk      = (shreg_q == '0) && !(pen_q && pbit_q) && !rxd_s;

    always_comb begin
        state_d = state_q;
        os_d    = os_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        nb_d    = nb_q;
        pen_d   = pen_q;
        podd_d  = podd_q;
        pbit_d  = pbit_q;
        wait_d  = wait_q;
        word_d  = word_q;
        push_d  = 1'b0;
        div_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (wait_q) begin
                    if (rxd_s) wait_d = 1'b0;
                end else if (rxd_prev && !rxd_s) begin
                    state_d = START;
                    os_d    = '0;
                    shreg_d = '0;
                    nb_d    = cfg_data_bits_i;
                    pen_d   = cfg_parity_en_i;
                    podd_d  = cfg_parity_odd_i;
                    div_clr = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (os_q == OS_HALF) begin
                        os_d    = '0;
                        bit_d   = '0;
                        state_d = rxd_s ? IDLE : DATA;
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (os_q == OS_LAST) begin
                        os_d           = '0;
                        shreg_d[bit_q] = rxd_s;
                        if (last_bit) state_d = pen_q ? PARITY : STOP;
                        else          bit_d   = bit_q + 1'b1;
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (os_q == OS_LAST) begin
                        os_d    = '0;
                        pbit_d  = rxd_s;
                        state_d = STOP;
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (os_q == OS_LAST) begin
                        os_d    = '0;
                        state_d = IDLE;
                        push_d  = 1'b1;
                        word_d  = {brk, frm_err, par_err, shreg_q};
                        wait_d  = frm_err;
                    end else begin
                        os_d = os_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            os_q    <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            nb_q    <= '0;
            pen_q   <= 1'b0;
            podd_q  <= 1'b0;
            pbit_q  <= 1'b0;
            wait_q  <= 1'b0;
            push_q  <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            os_q    <= os_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            nb_q    <= nb_d;
            pen_q   <= pen_d;
            podd_q  <= podd_d;
            pbit_q  <= pbit_d;
            wait_q  <= wait_d;
            push_q  <= push_d;
            word_q  <= word_d;
        end
    end

    logic [10:0]   mem [FIFO_DEPTH];
    logic [10:0]   head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          pop, wr_en;

    assign pop   = rd_en_i && !rx_empty_o;
    assign wr_en = push_q && (!rx_full_o || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= word_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)      count <= count + 1'b1;
            else if (!wr_en && pop) count <= count - 1'b1;
            overrun_o <= push_q && rx_full_o && !pop;
        end
    end

    assign head       = mem[rd_ptr];
    assign rx_empty_o = (count == '0);
    assign rx_full_o  = (count == CW'(FIFO_DEPTH));
    assign rx_count_o = count;
    assign rd_data_o  = rx_empty_o ? '0 : head[7:0];
    assign rd_err_o   = rx_empty_o ? '0 : head[10:8];
    assign rx_trig_o  = (cfg_trig_lvl_i != '0) && (count >= cfg_trig_lvl_i);
    assign rts_o      = (count >= CW'(FIFO_DEPTH - 2));

`ifdef UART_RX_TIMEOUT_EN
    localparam int unsigned TO_LIMIT = 40 * OVERSAMPLE;
    localparam int unsigned TOW      = $clog2(TO_LIMIT);
    logic [TOW-1:0] to_cnt;
    logic           to_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            to_q   <= 1'b0;
        end else if (push_q || pop || rx_empty_o) begin
            to_cnt <= '0;
            to_q   <= 1'b0;
        end else if (tick && state_q == IDLE && !to_q) begin
            if (to_cnt == TOW'(TO_LIMIT - 1)) to_q   <= 1'b1;
            else                              to_cnt <= to_cnt + 1'b1;
        end
    end
    assign timeout_o = to_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Directed self-checking bench for uart_rx_fifo_param (depth 16, 16x oversample, baud_div_i=0).
// Timeout scenario is exercised when UART_RX_TIMEOUT_EN is defined.
module tb_uart_rx_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [15:0] baud_div = '0;
    logic [1:0] data_bits = 2'b11;
    logic       par_en = 1'b0, par_odd = 1'b0;
    logic [4:0] trig_lvl = '0;
    logic       rxd = 1'b1, rd_en = 1'b0;
    logic [7:0] rd_data;
    logic [2:0] rd_err;
    logic       empty, full, overrun, trig, rts, timeout;
    logic [4:0] count;

    int checks = 0;
    int failures = 0;
    int ovr_cnt = 0;

    uart_rx_fifo_param #(.FIFO_DEPTH(16), .OVERSAMPLE(16), .DIV_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .baud_div_i(baud_div),
        .cfg_data_bits_i(data_bits), .cfg_parity_en_i(par_en), .cfg_parity_odd_i(par_odd),
        .cfg_trig_lvl_i(trig_lvl), .rxd_i(rxd), .rd_en_i(rd_en),
        .rd_data_o(rd_data), .rd_err_o(rd_err), .rx_empty_o(empty), .rx_full_o(full),
        .rx_count_o(count), .overrun_o(overrun), .rx_trig_o(trig), .rts_o(rts),
        .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (overrun) ovr_cnt <= ovr_cnt + 1;

    // One bit is 16 clocks at baud_div_i=0; called and returns on a falling clock edge.
    task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                              input logic pbit, input logic stopb);
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rxd = d[i];
            repeat (16) @(negedge clk);
        end
        if (pen) begin
            rxd = pbit;
            repeat (16) @(negedge clk);
        end
        rxd = stopb;
        repeat (16) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rxd = 1'b1; rd_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (rd_data !== 8'h00 || rd_err !== 3'b000) begin failures++; $display("FAIL reset_data got=%h/%b exp=00/000", rd_data, rd_err); end
        checks++; if ({overrun, trig, rts, timeout} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {overrun, trig, rts, timeout}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_latency();
        int cnt = 0;
        data_bits = 2'b11; par_en = 1'b0;
        fork
            send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
            begin
                while (empty && cnt < 300) begin
                    @(negedge clk);
                    cnt++;
                end
            end
        join
        checks++; if (cnt < 152 || cnt > 156) begin failures++; $display("FAIL latency_55 got=%0d exp=152..156", cnt); end
        checks++; if (rd_data !== 8'h55 || rd_err !== 3'b000) begin failures++; $display("FAIL data_55 got=%h/%b exp=55/000", rd_data, rd_err); end
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL count_55 got=%0d exp=1", count); end
        pop_one();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL pop_55 empty got=%b exp=1", empty); end
    endtask

    task automatic test_parity();
        data_bits = 2'b10; par_en = 1'b1; par_odd = 1'b0;
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (rd_data !== 8'h41 || rd_err !== 3'b001) begin failures++; $display("FAIL par_even_bad got=%h/%b exp=41/001", rd_data, rd_err); end
        pop_one();
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (rd_data !== 8'h41 || rd_err !== 3'b000) begin failures++; $display("FAIL par_even_ok got=%h/%b exp=41/000", rd_data, rd_err); end
        pop_one();
        par_odd = 1'b1;
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (rd_data !== 8'h41 || rd_err !== 3'b001) begin failures++; $display("FAIL par_odd_bad got=%h/%b exp=41/001", rd_data, rd_err); end
        pop_one();
        data_bits = 2'b00; par_en = 1'b0; par_odd = 1'b0;
        send_frame(8'hFF, 5, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (rd_data !== 8'h1F || rd_err !== 3'b000) begin failures++; $display("FAIL five_bit got=%h/%b exp=1f/000", rd_data, rd_err); end
        pop_one();
        data_bits = 2'b11;
    endtask

    task automatic test_break();
        rxd = 1'b0;
        repeat (200) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL break_count got=%0d exp=1", count); end
        checks++; if (rd_data !== 8'h00 || rd_err !== 3'b110) begin failures++; $display("FAIL break_data got=%h/%b exp=00/110", rd_data, rd_err); end
        pop_one();
        send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (rd_data !== 8'h96 || rd_err !== 3'b000 || count !== 5'd1) begin failures++; $display("FAIL after_break got=%h/%b/%0d exp=96/000/1", rd_data, rd_err, count); end
        pop_one();
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (60) @(negedge clk);
        checks++; if (empty !== 1'b1 || count !== 5'd0) begin failures++; $display("FAIL glitch_push got=%b/%0d exp=1/0", empty, count); end
        send_frame(8'hA3, 8, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (rd_data !== 8'hA3 || count !== 5'd1) begin failures++; $display("FAIL after_glitch got=%h/%0d exp=a3/1", rd_data, count); end
        pop_one();
    endtask

    task automatic test_midframe_reset();
        rxd = 1'b0;
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (empty !== 1'b1 || count !== 5'd0) begin failures++; $display("FAIL midframe_reset got=%b/%0d exp=1/0", empty, count); end
    endtask

    task automatic test_fill_overrun();
        int ovr_base;
        logic [7:0] d, exp_d;
        trig_lvl = 5'd4;
        ovr_base = ovr_cnt;
        for (int i = 0; i < 17; i++) begin
            d = 8'h10 + 8'(i);
            send_frame(d, 8, 1'b0, 1'b0, 1'b1);
            repeat (2) @(negedge clk);
            if (i == 2) begin
                checks++; if (trig !== 1'b0 || count !== 5'd3) begin failures++; $display("FAIL trig_below got=%b/%0d exp=0/3", trig, count); end
            end
            if (i == 3) begin
                checks++; if (trig !== 1'b1) begin failures++; $display("FAIL trig_at got=%b exp=1", trig); end
            end
            if (i == 12) begin
                checks++; if (rts !== 1'b0 || count !== 5'd13) begin failures++; $display("FAIL rts_13 got=%b/%0d exp=0/13", rts, count); end
            end
            if (i == 13) begin
                checks++; if (rts !== 1'b1 || count !== 5'd14) begin failures++; $display("FAIL rts_14 got=%b/%0d exp=1/14", rts, count); end
            end
            if (i == 14) begin
                checks++; if (full !== 1'b0) begin failures++; $display("FAIL full_15 got=%b exp=0", full); end
            end
            if (i == 15) begin
                checks++; if (full !== 1'b1 || count !== 5'd16) begin failures++; $display("FAIL full_16 got=%b/%0d exp=1/16", full, count); end
                checks++; if (ovr_cnt - ovr_base !== 0) begin failures++; $display("FAIL ovr_early got=%0d exp=0", ovr_cnt - ovr_base); end
            end
        end
        checks++; if (ovr_cnt - ovr_base !== 1) begin failures++; $display("FAIL overrun_pulses got=%0d exp=1", ovr_cnt - ovr_base); end
        checks++; if (count !== 5'd16 || rd_data !== 8'h10) begin failures++; $display("FAIL full_head got=%0d/%h exp=16/10", count, rd_data); end
        // Pop lands on the same edge the new word is written.
        fork
            send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
            begin
                repeat (155) @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        checks++; if (count !== 5'd16 || full !== 1'b1) begin failures++; $display("FAIL simul_count got=%0d/%b exp=16/1", count, full); end
        checks++; if (ovr_cnt - ovr_base !== 1) begin failures++; $display("FAIL simul_overrun got=%0d exp=1", ovr_cnt - ovr_base); end
        for (int i = 0; i < 16; i++) begin
            exp_d = (i < 15) ? (8'h11 + 8'(i)) : 8'hC3;
            checks++; if (rd_data !== exp_d || empty !== 1'b0) begin failures++; $display("FAIL drain_%0d got=%h exp=%h", i, rd_data, exp_d); end
            pop_one();
        end
        checks++; if (empty !== 1'b1 || count !== 5'd0) begin failures++; $display("FAIL drained got=%b/%0d exp=1/0", empty, count); end
        pop_one();
        checks++; if (empty !== 1'b1 || count !== 5'd0) begin failures++; $display("FAIL pop_empty got=%b/%0d exp=1/0", empty, count); end
        trig_lvl = '0;
    endtask

    task automatic test_timeout();
`ifdef UART_RX_TIMEOUT_EN
        int wait_cnt = 0;
        int to_cnt = 0;
        fork
            send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
            begin
                while (empty && wait_cnt < 300) begin
                    @(negedge clk);
                    wait_cnt++;
                end
                while (!timeout && to_cnt < 1000) begin
                    @(negedge clk);
                    to_cnt++;
                end
            end
        join
        checks++; if (to_cnt < 639 || to_cnt > 641) begin failures++; $display("FAIL timeout_delay got=%0d exp=640", to_cnt); end
        pop_one();
        checks++; if (timeout !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL timeout_clear got=%b/%b exp=0/1", timeout, empty); end
`else
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        repeat (700) @(negedge clk);
        checks++; if (timeout !== 1'b0 || empty !== 1'b0) begin failures++; $display("FAIL timeout_absent got=%b/%b exp=0/0", timeout, empty); end
        pop_one();
`endif
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_latency();
        test_parity();
        test_break();
        test_glitch();
        test_midframe_reset();
        test_fill_overrun();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
